// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder stage reused LSB first, with the
// ripple carry held in a flop and sum bits collected in a shift register.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_IN_BIT = CW'(WIDTH - 2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic fa_x;
  logic fa_s;
  logic fa_c;

  // The single full-adder stage shared by every bit position.
  assign fa_x = a_q[0] ^ b_q[0];
  assign fa_s = fa_x ^ carry_q;
  assign fa_c = (a_q[0] & b_q[0]) | (fa_x & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sr_d    = {fa_s, sr_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == MSB_IN_BIT) begin
          c_msb_d = fa_c;
        end
        // Last bit: publish everything at once so partial results never show.
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_s, sr_q[WIDTH-1:1]};
          cout_d  = fa_c;
          ovf_d   = c_msb_q ^ fa_c;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for directed/random
// work and a 2-bit instance for the exhaustive sweep.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int checks = 0;
  int errors = 0;

  logic [33:0] q8[$];
  logic [33:0] q2[$];
  logic [7:0]  lastSum8 = '0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  // Reference: whole-word arithmetic; ovf from operand/result signs.
  function automatic logic [33:0] refModel(input int w, input logic [31:0] ia,
                                           input logic [31:0] ib, input logic icin,
                                           input logic isub);
    longint unsigned mask, av, bv, full, s;
    logic co, ov, sa, sb, ss;
    mask = (64'd1 << w) - 64'd1;
    av   = {32'd0, ia} & mask;
    bv   = {32'd0, ib} & mask;
    if (isub) bv = mask - bv;
    full = av + bv + (isub ? 64'd1 : {63'd0, icin});
    s    = full & mask;
    co   = full[w];
    sa   = av[w-1];
    sb   = bv[w-1];
    ss   = s[w-1];
    ov   = (sa == sb) && (ss != sa);
    return {ov, co, s[31:0]};
  endfunction

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n && done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("[TB] FAIL w8_unexpected_done: got sum=%h cout=%b ovf=%b, required no done",
                 sum8, cout8, ovf8);
      end else begin
        e = q8.pop_front();
        if ({ovf8, cout8, sum8} !== {e[33], e[32], e[7:0]}) begin
          errors++;
          $display("[TB] FAIL w8_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   sum8, cout8, ovf8, e[7:0], e[32], e[33]);
        end
      end
    end
  end

  // Monitor for the 2-bit instance.
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n && done2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("[TB] FAIL w2_unexpected_done: got sum=%h cout=%b ovf=%b", sum2, cout2, ovf2);
      end else begin
        e = q2.pop_front();
        if ({ovf2, cout2, sum2} !== {e[33], e[32], e[1:0]}) begin
          errors++;
          $display("[TB] FAIL w2_case: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   sum2, cout2, ovf2, e[1:0], e[32], e[33]);
        end else begin
          $display("[TB] PASS w2_case: sum=%h cout=%b ovf=%b", sum2, cout2, ovf2);
        end
      end
    end
  end

  task automatic checkZero(input string name);
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0 || {busy2, done2, sum2, cout2, ovf2} !== 6'd0) begin
      errors++;
      $display("[TB] FAIL %s: got w8 busy=%b done=%b sum=%h cout=%b ovf=%b w2 busy=%b sum=%h, required all 0",
               name, busy8, done8, sum8, cout8, ovf8, busy2, sum2);
    end
  endtask

  // Drives one request; returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib,
                               input logic icin, input logic isub);
    @(negedge clk);
    a8 = ia; b8 = ib; cin8 = icin; sub8 = isub; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_start: got %b, required 1", busy8);
    end
  endtask

  // Timing checks around one operation; values are checked by the monitor.
  task automatic checkOutput(input logic [7:0] expSum, input bit disturb);
    int n;
    bit holdBad;
    n = 0;
    holdBad = 1'b0;
    while (done8 !== 1'b1 && n < 40) begin
      if (sum8 !== lastSum8) holdBad = 1'b1;
      if (disturb && n == 2) begin
        a8 = ~a8; b8 = 8'($urandom); cin8 = ~cin8; sub8 = ~sub8; start8 = 1'b1;
      end
      if (disturb && n == 3) start8 = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("[TB] FAIL done_latency: got %0d edges, required 8", n);
    end
    checks++;
    if (holdBad) begin
      errors++;
      $display("[TB] FAIL sum_hold: got changing sum during run, required %h held", lastSum8);
    end
    @(posedge clk); #1;
    checks++;
    if ({done8, busy8} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL done_pulse: got done=%b busy=%b, required 0 0", done8, busy8);
    end
    lastSum8 = expSum;
  endtask

  task automatic runOp8(input logic [7:0] ia, input logic [7:0] ib,
                        input logic icin, input logic isub, input bit disturb);
    logic [33:0] e;
    e = refModel(8, {24'd0, ia}, {24'd0, ib}, icin, isub);
    q8.push_back(e);
    applyStimulus(ia, ib, icin, isub);
    checkOutput(e[7:0], disturb);
  endtask

  task automatic runOp2(input logic [1:0] ia, input logic [1:0] ib,
                        input logic icin, input logic isub);
    int n;
    q2.push_back(refModel(2, {30'd0, ia}, {30'd0, ib}, icin, isub));
    @(negedge clk);
    a2 = ia; b2 = ib; cin2 = icin; sub2 = isub; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("[TB] FAIL w2_timeout: got no done in %0d edges, required done", n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkZero("reset_state");

    runOp8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    runOp8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    runOp8(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);
    runOp8(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    runOp8(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    runOp8(8'h12, 8'h34, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      runOp8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    // Abort after four RUN edges: no done may follow.
    applyStimulus(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkZero("reset_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    lastSum8 = '0;
    repeat (12) @(negedge clk);
    checkZero("reset_release_idle");

    runOp8(8'hC3, 8'h5A, 1'b1, 1'b1, 1'b0);
    runOp8(8'h01, 8'h01, 1'b1, 1'b0, 1'b0);

    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int c = 0; c < 2; c++)
          for (int s = 0; s < 2; s++)
            runOp2(2'(ia), 2'(ib), 1'(c), 1'(s));

    repeat (4) @(negedge clk);
    checks++;
    if (q8.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", q8.size(), q2.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
